// File: rtl/tlul_xspi_retry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlul_xspi_retry_ctrl
// Description : Single-outstanding TL-UL to xSPI 8S bridge. Retries failed
//               attempts after a CRC error or timeout, with a fixed backoff.
//               Optional counters are enabled by XSPI_RETRY_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_xspi_retry_ctrl #(
   parameter int         TL_ADDR_WIDTH   = 64,
   parameter int         TL_DATA_WIDTH   = 64,
   parameter int         TL_SOURCE_WIDTH = 3,
   parameter int         MAX_RETRY       = 3,
   parameter int         BACKOFF_CYC     = 4,
   parameter int         TIMEOUT_CYC     = 1024,
   parameter logic [7:0] CMD_RD          = 8'h03,
   parameter logic [7:0] CMD_WR          = 8'h02
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             a_valid,
   output logic                             a_ready,
   input  logic [2:0]                       a_opcode,
   input  logic [TL_ADDR_WIDTH-1:0]         a_address,
   input  logic [TL_DATA_WIDTH-1:0]         a_data,
   input  logic [TL_SOURCE_WIDTH-1:0]       a_source,
   output logic                             d_valid,
   input  logic                             d_ready,
   output logic [2:0]                       d_opcode,
   output logic [TL_SOURCE_WIDTH-1:0]       d_source,
   output logic [TL_DATA_WIDTH-1:0]         d_data,
   output logic                             d_error,
   output logic                             spi_start,
   output logic [7:0]                       spi_cmd,
   output logic [23:0]                      spi_addr,
   output logic [31:0]                      spi_wdata,
   input  logic                             spi_done,
   input  logic                             spi_crc_err,
   input  logic [31:0]                      spi_rdata,
   output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
`ifdef XSPI_RETRY_STATS_EN
   ,
   output logic [15:0]                      stat_retries,
   output logic [15:0]                      stat_fails
`endif
);

   localparam int         c_RC_W   = $clog2(MAX_RETRY + 1);
   localparam int         c_TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int         c_BO_W   = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
   localparam logic [2:0] c_OP_PUT = 3'd0;
   localparam logic [2:0] c_OP_GET = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   state_e                       r_state;
   state_e                       w_next;
   logic                         r_is_get;
   logic                         r_err;
   logic [7:0]                   r_cmd;
   logic [23:0]                  r_addr;
   logic [31:0]                  r_wdata;
   logic [31:0]                  r_rdata;
   logic [TL_SOURCE_WIDTH-1:0]   r_source;
   logic [c_RC_W-1:0]            r_retry;
   logic [c_TMO_W-1:0]           r_tmo;
   logic [c_BO_W-1:0]            r_bo;

   logic w_accept;
   logic w_op_ok;
   logic w_timeout;
   logic w_ok;
   logic w_retry;
   logic w_exhaust;
   logic w_unused;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A clean spi_done is tested first so it wins over a same-cycle timeout.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_ok      = 1'b0;
      w_retry   = 1'b0;
      w_exhaust = 1'b0;
      w_op_ok   = (a_opcode == c_OP_PUT) || (a_opcode == c_OP_GET);
      w_timeout = (r_tmo == c_TMO_W'(TIMEOUT_CYC - 1));
      case (r_state)
         ST_IDLE: begin
            if (a_valid) begin
               w_accept = 1'b1;
               w_next   = w_op_ok ? ST_ISSUE : ST_RESP;
            end
         end
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT: begin
            if (spi_done && !spi_crc_err) begin
               w_ok   = 1'b1;
               w_next = ST_RESP;
            end else if (spi_done || w_timeout) begin
               if (r_retry == c_RC_W'(MAX_RETRY)) begin
                  w_exhaust = 1'b1;
                  w_next    = ST_RESP;
               end else begin
                  w_retry = 1'b1;
                  w_next  = ST_BACKOFF;
               end
            end
         end
         ST_BACKOFF: begin
            if (r_bo == c_BO_W'(BACKOFF_CYC - 1)) begin
               w_next = ST_ISSUE;
            end
         end
         ST_RESP: begin
            if (d_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_get <= 1'b0;
         r_err    <= 1'b0;
         r_cmd    <= 8'h00;
         r_addr   <= 24'h0;
         r_wdata  <= 32'h0;
         r_rdata  <= 32'h0;
         r_source <= '0;
         r_retry  <= '0;
         r_tmo    <= '0;
         r_bo     <= '0;
      end else begin
         if (w_accept) begin
            r_is_get <= (a_opcode == c_OP_GET);
            r_err    <= !w_op_ok;
            r_cmd    <= (a_opcode == c_OP_GET) ? CMD_RD :
                        (a_opcode == c_OP_PUT) ? CMD_WR : 8'h00;
            r_addr   <= a_address[23:0];
            r_wdata  <= a_data[31:0];
            r_source <= a_source;
            r_rdata  <= 32'h0;
            r_retry  <= '0;
         end
         if (w_ok && r_is_get) begin
            r_rdata <= spi_rdata;
         end
         if (w_exhaust) begin
            r_err <= 1'b1;
         end
         // Only reached while below MAX_RETRY, so the count never wraps.
         if (w_retry) begin
            r_retry <= r_retry + 1'b1;
         end
         r_tmo <= (r_state == ST_WAIT)    ? r_tmo + 1'b1 : '0;
         r_bo  <= (r_state == ST_BACKOFF) ? r_bo + 1'b1  : '0;
      end
   end

   assign a_ready   = (r_state == ST_IDLE);
   assign d_valid   = (r_state == ST_RESP);
   assign spi_start = (r_state == ST_ISSUE);
   assign d_opcode  = {2'b00, r_is_get};
   assign d_source  = r_source;
   assign d_data    = TL_DATA_WIDTH'(r_rdata);
   assign d_error   = r_err;
   assign spi_cmd   = r_cmd;
   assign spi_addr  = r_addr;
   assign spi_wdata = r_wdata;
   assign retry_cnt = r_retry;

   // Upper address/data bits are architecturally ignored.
   assign w_unused  = ^{a_address, a_data};

`ifdef XSPI_RETRY_STATS_EN
   logic [15:0] r_stat_retries;
   logic [15:0] r_stat_fails;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_retries <= 16'h0;
         r_stat_fails   <= 16'h0;
      end else begin
         if (w_retry && (r_stat_retries != 16'hFFFF)) begin
            r_stat_retries <= r_stat_retries + 16'h1;
         end
         if ((w_exhaust || (w_accept && !w_op_ok)) && (r_stat_fails != 16'hFFFF)) begin
            r_stat_fails <= r_stat_fails + 16'h1;
         end
      end
   end

   assign stat_retries = r_stat_retries;
   assign stat_fails   = r_stat_fails;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlul_xspi_retry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlul_xspi_retry_ctrl
// Description : Scoreboard bench for tlul_xspi_retry_ctrl with a scripted
//               xSPI responder (latency, CRC failures, silence, forced done).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlul_xspi_retry_ctrl;

   localparam int MAX_RETRY   = 3;
   localparam int BACKOFF_CYC = 4;
   localparam int TIMEOUT_CYC = 1024;
   localparam int BUDGET      = 6000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [2:0]  a_opcode = 3'd0;
   logic [63:0] a_address = 64'h0;
   logic [63:0] a_data = 64'h0;
   logic [2:0]  a_source = 3'd0;
   logic        d_valid;
   logic        d_ready = 1'b0;
   logic [2:0]  d_opcode;
   logic [2:0]  d_source;
   logic [63:0] d_data;
   logic        d_error;
   logic        spi_start;
   logic [7:0]  spi_cmd;
   logic [23:0] spi_addr;
   logic [31:0] spi_wdata;
   logic        spi_done = 1'b0;
   logic        spi_crc_err = 1'b0;
   logic [31:0] spi_rdata = 32'h0;
   logic [1:0]  retry_cnt;
`ifdef XSPI_RETRY_STATS_EN
   logic [15:0] stat_retries;
   logic [15:0] stat_fails;
`endif

   tlul_xspi_retry_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_opcode    (a_opcode),
      .a_address   (a_address),
      .a_data      (a_data),
      .a_source    (a_source),
      .d_valid     (d_valid),
      .d_ready     (d_ready),
      .d_opcode    (d_opcode),
      .d_source    (d_source),
      .d_data      (d_data),
      .d_error     (d_error),
      .spi_start   (spi_start),
      .spi_cmd     (spi_cmd),
      .spi_addr    (spi_addr),
      .spi_wdata   (spi_wdata),
      .spi_done    (spi_done),
      .spi_crc_err (spi_crc_err),
      .spi_rdata   (spi_rdata),
      .retry_cnt   (retry_cnt)
`ifdef XSPI_RETRY_STATS_EN
      ,
      .stat_retries(stat_retries),
      .stat_fails  (stat_fails)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic        err;
      logic [2:0]  src;
      logic [63:0] data;
      int          starts;
      logic [1:0]  retry;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          errors  = 0;

   // Responder state and observation log
   int          cyc = 0;
   int          pend, attempt, fail_first, lat, done_at;
   bit          mute;
   logic [31:0] rd_val;
   int          start_q[$];
   int          done_q[$];
   logic [7:0]  cmd_q[$];
   logic [23:0] addr_q[$];
   logic [31:0] wdata_q[$];

   task automatic reset_resp();
      pend = -1; attempt = 0; fail_first = 0; lat = 2; done_at = -1;
      mute = 1'b0; rd_val = 32'h0;
      start_q.delete(); done_q.delete(); cmd_q.delete(); addr_q.delete(); wdata_q.delete();
   endtask

   // One clock: inputs change and outputs are observed on the falling edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      spi_done = 1'b0; spi_crc_err = 1'b0; spi_rdata = 32'h0;
      if (done_at == cyc) begin
         spi_done = 1'b1; spi_rdata = rd_val; done_q.push_back(cyc);
      end else if (pend == 0) begin
         spi_done = 1'b1; spi_crc_err = (attempt <= fail_first); spi_rdata = rd_val;
         pend = -1; done_q.push_back(cyc);
      end else if (pend > 0) begin
         pend--;
      end
      if (spi_start === 1'b1) begin
         attempt++;
         start_q.push_back(cyc); cmd_q.push_back(spi_cmd);
         addr_q.push_back(spi_addr); wdata_q.push_back(spi_wdata);
         if (!mute) pend = lat;
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data,
                       input logic [2:0] src, output int acc);
      a_valid = 1'b1; a_opcode = op; a_address = addr; a_data = data; a_source = src;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         if (a_ready === 1'b1) begin
            acc = cyc;
            tick();
            break;
         end
         tick();
      end
      a_valid = 1'b0;
   endtask

   task automatic wait_resp(output int at);
      at = -1;
      for (int i = 0; i < BUDGET; i++) begin
         if (d_valid === 1'b1) begin
            at = cyc;
            break;
         end
         tick();
      end
   endtask

   task automatic ack();
      d_ready = 1'b1; tick(); d_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; reset_resp();
      repeat (3) tick();
      vectors++;
      if (a_ready !== 1'b1) begin
         errors++; $display("FAIL reset_a_ready: got %b want 1", a_ready);
      end
      vectors++;
      if ({d_valid, spi_start, d_error} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 000", {d_valid, spi_start, d_error});
      end
      vectors++;
      if ({spi_cmd, spi_addr, spi_wdata, d_data, retry_cnt, d_opcode, d_source} !== '0) begin
         errors++; $display("FAIL reset_data: cmd %h addr %h wdata %h ddata %h retry %0d want all 0",
                            spi_cmd, spi_addr, spi_wdata, d_data, retry_cnt);
      end
      rst = 1'b0; tick();
   endtask

   task automatic test_get_clean();
      exp_t e; int acc, at; int first; logic [7:0] c; logic [23:0] ad;
      reset_resp(); rd_val = 32'hDEADBEEF;
      sb.push_back('{op: 3'd1, err: 1'b0, src: 3'd5, data: 64'hDEADBEEF, starts: 1, retry: 2'd0});
      send(3'd4, 64'h0000_00FF_0012_3456, 64'h0, 3'd5, acc);
      wait_resp(at);
      e = sb.pop_front();
      first = (start_q.size() > 0) ? start_q[0] : -1;
      c     = (cmd_q.size() > 0) ? cmd_q[0] : 8'h00;
      ad    = (addr_q.size() > 0) ? addr_q[0] : 24'h0;
      vectors++;
      if (first !== acc + 1) begin
         errors++; $display("FAIL get_first_start: got cycle %0d want %0d", first, acc + 1);
      end
      vectors++;
      if ({c, ad} !== {8'h03, 24'h123456}) begin
         errors++; $display("FAIL get_cmd_addr: got %h/%h want 03/123456", c, ad);
      end
      vectors++;
      if ({d_valid, d_opcode, d_error, d_source, d_data} !== {1'b1, e.op, e.err, e.src, e.data}) begin
         errors++; $display("FAIL get_resp: got op %0d err %b src %0d data %h want op %0d err %b src %0d data %h",
                            d_opcode, d_error, d_source, d_data, e.op, e.err, e.src, e.data);
      end
      vectors++;
      if (start_q.size() !== e.starts) begin
         errors++; $display("FAIL get_starts: got %0d want %0d", start_q.size(), e.starts);
      end
      ack();
      vectors++;
      if ({a_ready, d_valid} !== 2'b10) begin
         errors++; $display("FAIL get_return_idle: a_ready/d_valid got %b want 10", {a_ready, d_valid});
      end
   endtask

   task automatic test_put_retry();
      exp_t e; int acc, at, gap; logic [31:0] wd; logic [7:0] c;
      reset_resp(); fail_first = 2; rd_val = 32'h5555AAAA;
      sb.push_back('{op: 3'd0, err: 1'b0, src: 3'd2, data: 64'h0, starts: 3, retry: 2'd2});
      send(3'd0, 64'h0000_0000_0000_0100, 64'hFFFF_0000_0000_A5A5, 3'd2, acc);
      wait_resp(at);
      e  = sb.pop_front();
      wd = (wdata_q.size() > 0) ? wdata_q[0] : 32'h0;
      c  = (cmd_q.size() > 0) ? cmd_q[0] : 8'h00;
      vectors++;
      if ({c, wd} !== {8'h02, 32'h0000A5A5}) begin
         errors++; $display("FAIL put_cmd_wdata: got %h/%h want 02/0000a5a5", c, wd);
      end
      vectors++;
      if (start_q.size() !== e.starts) begin
         errors++; $display("FAIL put_starts: got %0d want %0d", start_q.size(), e.starts);
      end
      for (int i = 0; i < 2; i++) begin
         gap = (start_q.size() > i + 1 && done_q.size() > i) ? start_q[i+1] - done_q[i] : -1;
         vectors++;
         if (gap !== BACKOFF_CYC + 1) begin
            errors++; $display("FAIL put_backoff_%0d: done-to-start got %0d want %0d", i, gap, BACKOFF_CYC + 1);
         end
      end
      vectors++;
      if (retry_cnt !== e.retry) begin
         errors++; $display("FAIL put_retry_cnt: got %0d want %0d", retry_cnt, e.retry);
      end
      vectors++;
      if ({d_valid, d_opcode, d_error, d_source, d_data} !== {1'b1, e.op, e.err, e.src, e.data}) begin
         errors++; $display("FAIL put_resp: got op %0d err %b src %0d data %h want op %0d err %b src %0d data %h",
                            d_opcode, d_error, d_source, d_data, e.op, e.err, e.src, e.data);
      end
      ack();
   endtask

   task automatic test_get_exhaust();
      exp_t e; int acc, at;
      reset_resp(); fail_first = 100; rd_val = 32'hCAFEF00D;
      sb.push_back('{op: 3'd1, err: 1'b1, src: 3'd7, data: 64'h0, starts: MAX_RETRY + 1, retry: 2'(MAX_RETRY)});
      send(3'd4, 64'h0000_0000_00AB_CDEF, 64'h0, 3'd7, acc);
      wait_resp(at);
      e = sb.pop_front();
      vectors++;
      if (start_q.size() !== e.starts) begin
         errors++; $display("FAIL exhaust_starts: got %0d want %0d", start_q.size(), e.starts);
      end
      vectors++;
      if (retry_cnt !== e.retry) begin
         errors++; $display("FAIL exhaust_retry_cnt: got %0d want %0d", retry_cnt, e.retry);
      end
      vectors++;
      if ({d_valid, d_opcode, d_error, d_source, d_data} !== {1'b1, e.op, e.err, e.src, e.data}) begin
         errors++; $display("FAIL exhaust_resp: got op %0d err %b src %0d data %h want op %0d err %b src %0d data %h",
                            d_opcode, d_error, d_source, d_data, e.op, e.err, e.src, e.data);
      end
      ack();
   endtask

   task automatic test_unsupported();
      exp_t e; int acc, at;
      reset_resp();
      sb.push_back('{op: 3'd0, err: 1'b1, src: 3'd3, data: 64'h0, starts: 0, retry: 2'd0});
      send(3'd2, 64'h0000_0000_0000_0040, 64'h1234_5678, 3'd3, acc);
      wait_resp(at);
      e = sb.pop_front();
      vectors++;
      if (at !== acc + 1) begin
         errors++; $display("FAIL unsup_latency: d_valid at %0d want %0d", at, acc + 1);
      end
      vectors++;
      if (start_q.size() !== e.starts) begin
         errors++; $display("FAIL unsup_starts: got %0d want %0d", start_q.size(), e.starts);
      end
      vectors++;
      if ({d_opcode, d_error, d_source, d_data, retry_cnt} !== {e.op, e.err, e.src, e.data, e.retry}) begin
         errors++; $display("FAIL unsup_resp: got op %0d err %b src %0d data %h retry %0d want op 0 err 1 src 3 data 0 retry 0",
                            d_opcode, d_error, d_source, d_data, retry_cnt);
      end
      ack();
   endtask

   task automatic test_timeout();
      exp_t e; int acc, at, gap;
      reset_resp(); mute = 1'b1;
      sb.push_back('{op: 3'd0, err: 1'b1, src: 3'd1, data: 64'h0, starts: MAX_RETRY + 1, retry: 2'(MAX_RETRY)});
      send(3'd0, 64'h0000_0000_0000_0200, 64'h0000_0000_0BAD_0BAD, 3'd1, acc);
      wait_resp(at);
      e = sb.pop_front();
      vectors++;
      if (start_q.size() !== e.starts) begin
         errors++; $display("FAIL tmo_starts: got %0d want %0d", start_q.size(), e.starts);
      end
      for (int i = 0; i < MAX_RETRY; i++) begin
         gap = (start_q.size() > i + 1) ? start_q[i+1] - start_q[i] : -1;
         vectors++;
         if (gap !== TIMEOUT_CYC + BACKOFF_CYC + 1) begin
            errors++; $display("FAIL tmo_spacing_%0d: got %0d want %0d", i, gap, TIMEOUT_CYC + BACKOFF_CYC + 1);
         end
      end
      vectors++;
      if ({d_opcode, d_error, d_source, d_data, retry_cnt} !== {e.op, e.err, e.src, e.data, e.retry}) begin
         errors++; $display("FAIL tmo_resp: got op %0d err %b src %0d data %h retry %0d want op 0 err 1 src 1 data 0 retry 3",
                            d_opcode, d_error, d_source, d_data, retry_cnt);
      end
      ack();

      // spi_done on the last WAIT cycle must count as completion
      reset_resp(); mute = 1'b1; rd_val = 32'h13579BDF;
      sb.push_back('{op: 3'd1, err: 1'b0, src: 3'd6, data: 64'h13579BDF, starts: 1, retry: 2'd0});
      send(3'd4, 64'h0000_0000_0000_0300, 64'h0, 3'd6, acc);
      done_at = acc + 1 + TIMEOUT_CYC;
      wait_resp(at);
      e = sb.pop_front();
      vectors++;
      if (start_q.size() !== e.starts) begin
         errors++; $display("FAIL tmo_collide_starts: got %0d want %0d", start_q.size(), e.starts);
      end
      vectors++;
      if ({d_opcode, d_error, d_source, d_data, retry_cnt} !== {e.op, e.err, e.src, e.data, e.retry}) begin
         errors++; $display("FAIL tmo_collide_resp: got op %0d err %b src %0d data %h retry %0d want op 1 err 0 src 6 data 13579bdf retry 0",
                            d_opcode, d_error, d_source, d_data, retry_cnt);
      end
      ack();
   endtask

   task automatic test_backpressure();
      exp_t e; int acc, at;
      reset_resp(); rd_val = 32'h0BADF00D;
      sb.push_back('{op: 3'd1, err: 1'b0, src: 3'd4, data: 64'h0BADF00D, starts: 1, retry: 2'd0});
      send(3'd4, 64'h0000_0000_0000_0400, 64'h0, 3'd4, acc);
      wait_resp(at);
      e = sb.pop_front();
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if ({d_valid, a_ready, d_opcode, d_error, d_source, d_data} !==
             {1'b1, 1'b0, e.op, e.err, e.src, e.data}) begin
            errors++; $display("FAIL bp_hold_%0d: got v %b rdy %b op %0d err %b src %0d data %h want v 1 rdy 0 op %0d err %b src %0d data %h",
                               k, d_valid, a_ready, d_opcode, d_error, d_source, d_data, e.op, e.err, e.src, e.data);
         end
         tick();
      end
      ack();
   endtask

   task automatic test_reset_mid();
      exp_t e; int acc, at; bit seen;
      reset_resp(); mute = 1'b1;
      send(3'd4, 64'h0000_0000_0000_0500, 64'h0, 3'd2, acc);
      repeat (5) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      rd_val = 32'h77777777; done_at = cyc + 3;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (d_valid !== 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL rstmid_no_resp: d_valid seen %b want 0", seen);
      end
      vectors++;
      if ({a_ready, spi_cmd, retry_cnt} !== {1'b1, 8'h00, 2'd0} || start_q.size() !== 1) begin
         errors++; $display("FAIL rstmid_idle: a_ready %b cmd %h retry %0d starts %0d want 1/00/0/1",
                            a_ready, spi_cmd, retry_cnt, start_q.size());
      end
      reset_resp();
      sb.push_back('{op: 3'd0, err: 1'b0, src: 3'd0, data: 64'h0, starts: 1, retry: 2'd0});
      send(3'd0, 64'h0000_0000_0000_0600, 64'h0000_0000_0000_0001, 3'd0, acc);
      wait_resp(at);
      e = sb.pop_front();
      vectors++;
      if ({d_valid, d_opcode, d_error, d_source, d_data} !== {1'b1, e.op, e.err, e.src, e.data} ||
          start_q.size() !== e.starts) begin
         errors++; $display("FAIL rstmid_recover: got v %b op %0d err %b src %0d data %h starts %0d want v 1 op 0 err 0 src 0 data 0 starts 1",
                            d_valid, d_opcode, d_error, d_source, d_data, start_q.size());
      end
      ack();
   endtask

   initial begin
      test_reset();
      test_get_clean();
      test_put_retry();
      test_get_exhaust();
      test_unsupported();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      vectors++;
      if (sb.size() !== 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
